run_counter_fsm: RTL and testbench

Parametrised run-controlled counter state machine: the generalised successor of the 2-bit Run/Reset counter logic. It holds its own state and count registers and advances a WIDTH-bit count on every clock where Run is high. It supports up/down direction, wrap or one-shot terminal behaviour, synchronous parallel load and a programmable terminal value. It drives the same nR/y control signals to downstream registers, plus terminal-count status.

---
 rtl/run_counter_fsm.sv | 66 ++++++
 tb/tb_run_counter_fsm.sv | 110 +++++++++++
 2 files changed

// File: rtl/run_counter_fsm.sv
// run_counter_fsm: run-controlled up/down counter FSM with wrap/one-shot terminal, load and nR/y controls
// Ports: Clk, Reset (async, active-high); Run, Dir, OneShot, Load, LoadVal in;
//        Q, State, Wrap, Done registered out; Tc, y, nR combinational out
module run_counter_fsm #(
   parameter int WIDTH    = 4,
   parameter int MAXCOUNT = 2**WIDTH-1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             Dir,
   input  logic             OneShot,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   output logic [WIDTH-1:0] Q,
   output logic [1:0]       State,
   output logic             Tc,
   output logic             Wrap,
   output logic             Done,
   output logic             y,
   output logic             nR
);
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] COUNT = 2'b01;
   localparam logic [1:0] PAUSE = 2'b10;
   localparam logic [1:0] DONE  = 2'b11;
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAXCOUNT);
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] load_q;
   // modulo MAXCOUNT+1: the terminal for the current direction wraps to the opposite end
   always_comb begin
      Tc     = Dir ? (Q == '0) : (Q == MAXV);
      step_q = Tc ? (Dir ? MAXV : '0) : (Dir ? Q - 1'b1 : Q + 1'b1);
      load_q = (LoadVal > MAXV) ? MAXV : LoadVal;
      y      = Run && (Q != '0);
      nR     = ~Reset;
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Q     <= '0;
         State <= IDLE;
         Wrap  <= 1'b0;
         Done  <= 1'b0;
      end else if (Load) begin
         Q     <= load_q;
         State <= IDLE;
         Wrap  <= 1'b0;
         Done  <= 1'b0;
      end else if (State == DONE) begin
         Wrap  <= 1'b0;
      end else if (Run) begin
         if (Tc && OneShot) begin
            State <= DONE;
            Done  <= 1'b1;
            Wrap  <= 1'b0;
         end else begin
            Q     <= step_q;
            State <= COUNT;
            Wrap  <= Tc;
         end
      end else begin
         Wrap  <= 1'b0;
         State <= (State == COUNT) ? PAUSE : State;
      end
   end
endmodule

// File: tb/tb_run_counter_fsm.sv
// tb_run_counter_fsm: directed scoreboard bench for run_counter_fsm (WIDTH=4, MAXCOUNT=9)
module tb_run_counter_fsm;
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] COUNT = 2'b01;
   localparam logic [1:0] PAUSE = 2'b10;
   localparam logic [1:0] DONE  = 2'b11;
   typedef struct {
      string      tag;
      logic [3:0] q;
      logic [1:0] st;
      logic       wr;
      logic       dn;
      logic       tc;
      logic       y;
   } exp_t;
   logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Dir = 1'b0, OneShot = 1'b0, Load = 1'b0;
   logic [3:0] LoadVal = '0;
   logic [3:0] Q;
   logic [1:0] State;
   logic Tc, Wrap, Done, y, nR;
   int pass_cnt = 0;
   int total_cnt = 0;
   int fail_cnt = 0;
   exp_t sb[$];
   run_counter_fsm #(.WIDTH(4), .MAXCOUNT(9)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Dir(Dir), .OneShot(OneShot), .Load(Load),
      .LoadVal(LoadVal), .Q(Q), .State(State), .Tc(Tc), .Wrap(Wrap), .Done(Done), .y(y), .nR(nR)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // one clock: drive at negedge, push the expected result, compare just after the rising edge
   task automatic cyc(input string tag, input logic run, input logic dir, input logic os,
                      input logic ld, input logic [3:0] lv, input logic [3:0] q,
                      input logic [1:0] st, input logic wr, input logic dn);
      exp_t e;
      exp_t o;
      @(negedge Clk);
      Run = run; Dir = dir; OneShot = os; Load = ld; LoadVal = lv;
      e.tag = tag; e.q = q; e.st = st; e.wr = wr; e.dn = dn;
      e.tc = dir ? (q == 4'd0) : (q == 4'd9);
      e.y = run && (q != 4'd0);
      sb.push_back(e);
      @(posedge Clk);
      #1;
      o = sb.pop_front();
      chk({o.tag, ".q"}, 8'(Q), 8'(o.q));
      chk({o.tag, ".state"}, 8'(State), 8'(o.st));
      chk({o.tag, ".wrap"}, 8'(Wrap), 8'(o.wr));
      chk({o.tag, ".done"}, 8'(Done), 8'(o.dn));
      chk({o.tag, ".tc"}, 8'(Tc), 8'(o.tc));
      chk({o.tag, ".y"}, 8'(y), 8'(o.y));
   endtask
   task automatic do_reset(input string tag);
      Reset = 1'b1; Run = 1'b0; Load = 1'b0;
      #1;
      chk({tag, ".q"}, 8'(Q), 8'd0);
      chk({tag, ".state"}, 8'(State), 8'(IDLE));
      chk({tag, ".done"}, 8'(Done), 8'd0);
      chk({tag, ".wrap"}, 8'(Wrap), 8'd0);
      chk({tag, ".nr_low"}, 8'(nR), 8'd0);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk({tag, ".nr_high"}, 8'(nR), 8'd1);
   endtask
   initial begin
      logic [3:0] up_q [12];
      up_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      do_reset("por");
      for (int i = 0; i < 12; i++)
         cyc($sformatf("up%0d", i), 1, 0, 0, 0, 0, up_q[i], COUNT, up_q[i] == 4'd0, 0);
      cyc("up_stop", 0, 0, 0, 0, 0, 4'd2, PAUSE, 0, 0);
      do_reset("rst_dn");
      cyc("dn0", 1, 1, 0, 0, 0, 4'd9, COUNT, 1, 0);
      cyc("dn1", 1, 1, 0, 0, 0, 4'd8, COUNT, 0, 0);
      cyc("dn2", 1, 1, 0, 0, 0, 4'd7, COUNT, 0, 0);
      do_reset("rst_os");
      cyc("os_load", 0, 0, 1, 1, 4'd7, 4'd7, IDLE, 0, 0);
      cyc("os0", 1, 0, 1, 0, 0, 4'd8, COUNT, 0, 0);
      cyc("os1", 1, 0, 1, 0, 0, 4'd9, COUNT, 0, 0);
      cyc("os2", 1, 0, 1, 0, 0, 4'd9, DONE, 0, 1);
      cyc("os3", 1, 0, 1, 0, 0, 4'd9, DONE, 0, 1);
      cyc("os4", 1, 0, 1, 0, 0, 4'd9, DONE, 0, 1);
      cyc("os_dir", 1, 1, 0, 0, 0, 4'd9, DONE, 0, 1);
      cyc("os_idle", 0, 1, 1, 0, 0, 4'd9, DONE, 0, 1);
      cyc("done_load", 1, 0, 1, 1, 4'd3, 4'd3, IDLE, 0, 0);
      cyc("load_sat", 1, 0, 0, 1, 4'd15, 4'd9, IDLE, 0, 0);
      cyc("load_step", 1, 0, 0, 0, 0, 4'd0, COUNT, 1, 0);
      do_reset("rst_pause");
      cyc("p0", 1, 0, 0, 0, 0, 4'd1, COUNT, 0, 0);
      cyc("p1", 0, 0, 0, 0, 0, 4'd1, PAUSE, 0, 0);
      cyc("p2", 0, 0, 0, 0, 0, 4'd1, PAUSE, 0, 0);
      cyc("p3", 1, 0, 0, 0, 0, 4'd2, COUNT, 0, 0);
      do_reset("rst_async_prep");
      for (int i = 1; i <= 5; i++)
         cyc($sformatf("pre%0d", i), 1, 0, 0, 0, 0, 4'(i), COUNT, 0, 0);
      #2;
      do_reset("async");
      cyc("restart", 1, 0, 0, 0, 0, 4'd1, COUNT, 0, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
